// File: rtl/gmii_hcp_pkg.sv
// Shared definitions for the HCP GMII transmit path: FSM encodings, framing bytes, CRC32 constants.
package gmii_hcp_pkg;

  typedef enum logic [2:0] {
    idle_s = 3'd0,
    pre_s  = 3'd1,
    sfd_s  = 3'd2,
    tran_s = 3'd3,
    err_s  = 3'd4,
    ifg_s  = 3'd5,
    fcs_s  = 3'd6
  } gmii_tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8_hcp.sv
// Combinational reflected CRC32 update for one byte (LSB-first Ethernet order).
module crc32_d8_hcp
  import gmii_hcp_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/gmii_write_hcp.sv
// GMII transmit framer: FIFO words -> preamble/SFD/bytes/IFG with TX timestamp.
// Optional appended FCS when GMII_WRITE_FCS_EN is defined.
//
// state  | meaning
// idle_s | wait for a head word, discard stray body words
// pre_s  | PREAMBLE_LEN x 0x55
// sfd_s  | 0xD5, latch timer
// tran_s | pop and send frame bytes until the tail word
// err_s  | underflowed frame, drain FIFO through the tail
// ifg_s  | IFG_CYCLES low cycles on the pins
// fcs_s  | four complemented CRC bytes, LSB first
module gmii_write_hcp
  import gmii_hcp_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [8:0]  iv_data,
  input  logic        i_data_empty,
  output logic        o_data_rd,
  input  logic [18:0] timer,
  output logic [7:0]  ov_gmii_txd,
  output logic        o_gmii_tx_en,
  output logic        o_gmii_tx_er,
  output logic [18:0] ov_send_ts,
  output logic        o_ts_valid,
  output logic        o_pkt_sent_pulse,
  output logic        o_fifo_underflow_pulse,
  output logic [2:0]  report_gmii_write_hcp_state
);

  localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] IFG_LAST = 5'(IFG_CYCLES - 1);

  gmii_tx_state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       first, first_nxt;
  logic       head_avail;
  logic       pop;
  logic [7:0] txd_d;
  logic       en_d, er_d, ts_d, sent_d, uf_d;

  assign head_avail = !i_data_empty && iv_data[8];
  assign o_data_rd  = pop && reset_n;
  assign report_gmii_write_hcp_state = state;

`ifdef GMII_WRITE_FCS_EN
  logic [31:0] crc, crc_upd, fcs;

  crc32_d8_hcp u_crc32_d8_hcp (
    .crc      (crc),
    .data     (iv_data[7:0]),
    .crc_next (crc_upd)
  );

  assign fcs = ~crc;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                   crc <= CRC_INIT;
    else if (state == sfd_s)        crc <= CRC_INIT;
    else if (state == tran_s && pop) crc <= crc_upd;
  end
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= idle_s;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      first <= first_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    first_nxt = first;
    case (state)
      idle_s: if (head_avail) begin
        state_nxt = pre_s;
        cnt_nxt   = '0;
      end
      pre_s: if (cnt == PRE_LAST) begin
        state_nxt = sfd_s;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt + 5'd1;
      sfd_s: begin
        state_nxt = tran_s;
        first_nxt = 1'b1;
      end
      tran_s: begin
        if (i_data_empty) state_nxt = err_s;
        else if (first)   first_nxt = 1'b0;
        else if (iv_data[8]) begin
`ifdef GMII_WRITE_FCS_EN
          state_nxt = fcs_s;
`else
          state_nxt = ifg_s;
`endif
          cnt_nxt = '0;
        end
      end
      err_s: if (head_avail) begin
        state_nxt = ifg_s;
        cnt_nxt   = '0;
      end
      // Leaving straight for pre_s keeps the pin gap at exactly IFG_CYCLES.
      ifg_s: if (cnt == IFG_LAST) begin
        state_nxt = head_avail ? pre_s : idle_s;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt + 5'd1;
`ifdef GMII_WRITE_FCS_EN
      fcs_s: if (cnt == 5'd3) begin
        state_nxt = ifg_s;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt + 5'd1;
`endif
      default: begin
        state_nxt = idle_s;
        cnt_nxt   = '0;
        first_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    txd_d  = 8'h00;
    en_d   = 1'b0;
    er_d   = 1'b0;
    ts_d   = 1'b0;
    sent_d = 1'b0;
    uf_d   = 1'b0;
    case (state)
      idle_s: pop = !i_data_empty && !iv_data[8];
      pre_s: begin
        txd_d = PREAMBLE_BYTE;
        en_d  = 1'b1;
      end
      sfd_s: begin
        txd_d = SFD_BYTE;
        en_d  = 1'b1;
        ts_d  = 1'b1;
      end
      tran_s: begin
        en_d = 1'b1;
        if (i_data_empty) begin
          er_d = 1'b1;
          uf_d = 1'b1;
        end else begin
          pop   = 1'b1;
          txd_d = iv_data[7:0];
`ifndef GMII_WRITE_FCS_EN
          sent_d = !first && iv_data[8];
`endif
        end
      end
      err_s: pop = !i_data_empty;
`ifdef GMII_WRITE_FCS_EN
      fcs_s: begin
        en_d   = 1'b1;
        sent_d = (cnt == 5'd3);
        case (cnt[1:0])
          2'd0:    txd_d = fcs[7:0];
          2'd1:    txd_d = fcs[15:8];
          2'd2:    txd_d = fcs[23:16];
          default: txd_d = fcs[31:24];
        endcase
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ov_gmii_txd            <= '0;
      o_gmii_tx_en           <= 1'b0;
      o_gmii_tx_er           <= 1'b0;
      ov_send_ts             <= '0;
      o_ts_valid             <= 1'b0;
      o_pkt_sent_pulse       <= 1'b0;
      o_fifo_underflow_pulse <= 1'b0;
    end else begin
      ov_gmii_txd            <= txd_d;
      o_gmii_tx_en           <= en_d;
      o_gmii_tx_er           <= er_d;
      o_ts_valid             <= ts_d;
      o_pkt_sent_pulse       <= sent_d;
      o_fifo_underflow_pulse <= uf_d;
      if (ts_d) ov_send_ts <= timer;
    end
  end

endmodule

// File: tb/tb_gmii_write_hcp.sv
// Scoreboard bench for gmii_write_hcp: FIFO model, per-byte expected queue, gap/length monitors.
module tb_gmii_write_hcp;

  localparam int PRE = 7;
  localparam int IFG = 12;
`ifdef GMII_WRITE_FCS_EN
  localparam bit FCS = 1'b1;
`else
  localparam bit FCS = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [8:0]  iv_data;
  logic        i_data_empty;
  logic        o_data_rd;
  logic [18:0] timer;
  logic [7:0]  ov_gmii_txd;
  logic        o_gmii_tx_en, o_gmii_tx_er;
  logic [18:0] ov_send_ts;
  logic        o_ts_valid, o_pkt_sent_pulse, o_fifo_underflow_pulse;
  logic [2:0]  report_gmii_write_hcp_state;

  gmii_write_hcp #(.PREAMBLE_LEN(PRE), .IFG_CYCLES(IFG)) dut (
    .clk_sys                     (clk_sys),
    .reset_n                     (reset_n),
    .iv_data                     (iv_data),
    .i_data_empty                (i_data_empty),
    .o_data_rd                   (o_data_rd),
    .timer                       (timer),
    .ov_gmii_txd                 (ov_gmii_txd),
    .o_gmii_tx_en                (o_gmii_tx_en),
    .o_gmii_tx_er                (o_gmii_tx_er),
    .ov_send_ts                  (ov_send_ts),
    .o_ts_valid                  (o_ts_valid),
    .o_pkt_sent_pulse            (o_pkt_sent_pulse),
    .o_fifo_underflow_pulse      (o_fifo_underflow_pulse),
    .report_gmii_write_hcp_state (report_gmii_write_hcp_state)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  d;
    logic        er;
    logic        last;
    logic        uf;
    logic        ts;
    logic [18:0] tsv;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] fifo[$];
  logic [7:0] frm[$];
  int n_checks = 0, n_pass = 0;
  int pop_cnt = 0, en_cnt = 0, sent_cnt = 0, uf_cnt = 0;
  int low_run = 0, run_len = 0, last_gap = 0, last_len = 0;
  logic was_en = 1'b0;
  logic rd_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic er, input logic last,
                          input logic uf, input logic ts, input logic [18:0] tsv);
    exp_t e;
    e.d = d; e.er = er; e.last = last; e.uf = uf; e.ts = ts; e.tsv = tsv;
    exp_q.push_back(e);
  endtask

  task automatic push_header(input logic [18:0] tsv);
    for (int i = 0; i < PRE; i++) push_exp(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    push_exp(8'hD5, 1'b0, 1'b0, 1'b0, 1'b1, tsv);
  endtask

  // Queue frm[] into the FIFO as one frame and predict its pin bytes.
  task automatic queue_frame(input logic [18:0] tsv, input bit auto_fcs);
    logic [31:0] c;
    int n;
    n = frm.size();
    c = 32'hFFFFFFFF;
    push_header(tsv);
    for (int i = 0; i < n; i++) begin
      fifo.push_back({(i == 0 || i == n - 1), frm[i]});
      push_exp(frm[i], 1'b0, (!FCS && i == n - 1), 1'b0, 1'b0, '0);
      c = crc_byte(c, frm[i]);
    end
    if (FCS && auto_fcs) begin
      c = ~c;
      for (int k = 0; k < 4; k++) push_exp(c[8*k +: 8], 1'b0, (k == 3), 1'b0, 1'b0, '0);
    end
  endtask

  task automatic rand_frame(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo.size() != 0) && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    if (k >= budget) check_eq({tag, "_timeout"}, 32'(exp_q.size() + fifo.size()), 32'd0);
    repeat (IFG + 4) @(negedge clk_sys);
  endtask

  // Show-ahead FIFO model: pops on the edge that follows a sampled o_data_rd.
  initial begin
    iv_data = '0;
    i_data_empty = 1'b1;
    forever begin
      @(posedge clk_sys);
      #1;
      if (rd_seen && fifo.size() > 0) begin
        void'(fifo.pop_front());
        pop_cnt++;
      end
      iv_data      = (fifo.size() > 0) ? fifo[0] : 9'd0;
      i_data_empty = (fifo.size() == 0);
      @(negedge clk_sys);
      rd_seen = o_data_rd;
    end
  end

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      was_en  = 1'b0;
      low_run = 0;
      run_len = 0;
    end else if (o_gmii_tx_en) begin
      if (!was_en) begin
        last_gap = low_run;
        run_len  = 0;
      end
      run_len++;
      en_cnt++;
      if (o_pkt_sent_pulse) sent_cnt++;
      if (o_fifo_underflow_pulse) uf_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_tx", {24'd0, ov_gmii_txd}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("txd", {24'd0, ov_gmii_txd}, {24'd0, e.d});
        check_eq("tx_er", {31'd0, o_gmii_tx_er}, {31'd0, e.er});
        check_eq("sent_pulse", {31'd0, o_pkt_sent_pulse}, {31'd0, e.last});
        check_eq("uf_pulse", {31'd0, o_fifo_underflow_pulse}, {31'd0, e.uf});
        check_eq("ts_valid", {31'd0, o_ts_valid}, {31'd0, e.ts});
        if (e.ts) check_eq("send_ts", {13'd0, ov_send_ts}, {13'd0, e.tsv});
      end
      was_en = 1'b1;
    end else begin
      if (o_pkt_sent_pulse || o_fifo_underflow_pulse || o_ts_valid || o_gmii_tx_er)
        check_eq("pulse_while_idle",
                 {28'd0, o_pkt_sent_pulse, o_fifo_underflow_pulse, o_ts_valid, o_gmii_tx_er}, 32'd0);
      if (was_en) begin
        last_len = run_len;
        low_run  = 0;
      end
      low_run++;
      was_en = 1'b0;
    end
  end

  initial begin
    int s0, u0, p0, e0, k;
    reset_n = 1'b0;
    timer   = '0;
    repeat (3) @(negedge clk_sys);
    check_eq("rst_tx_en", {31'd0, o_gmii_tx_en}, 32'd0);
    check_eq("rst_txd", {24'd0, ov_gmii_txd}, 32'd0);
    check_eq("rst_state", {29'd0, report_gmii_write_hcp_state}, 32'd0);
    check_eq("rst_rd", {31'd0, o_data_rd}, 32'd0);
    reset_n = 1'b1;

    // Reset in the middle of the preamble
    rand_frame(8);
    timer = 19'h050;
    queue_frame(timer, 1'b1);
    e0 = en_cnt;
    k = 0;
    while (en_cnt < e0 + 3 && k < 100) begin @(negedge clk_sys); k++; end
    check_eq("pre_reached", 32'(en_cnt - e0), 32'd3);
    #1 reset_n = 1'b0;
    #1;
    check_eq("midrst_tx_en", {31'd0, o_gmii_tx_en}, 32'd0);
    check_eq("midrst_tx_er", {31'd0, o_gmii_tx_er}, 32'd0);
    check_eq("midrst_txd", {24'd0, ov_gmii_txd}, 32'd0);
    check_eq("midrst_pulses", {29'd0, o_ts_valid, o_pkt_sent_pulse, o_fifo_underflow_pulse}, 32'd0);
    check_eq("midrst_state", {29'd0, report_gmii_write_hcp_state}, 32'd0);
    check_eq("midrst_rd", {31'd0, o_data_rd}, 32'd0);
    exp_q.delete();
    fifo.delete();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // 64-word frame
    s0 = sent_cnt;
    rand_frame(64);
    timer = 19'h100;
    queue_frame(timer, 1'b1);
    wait_drain("frame64", 400);
    check_eq("frame64_len", 32'(last_len), 32'(PRE + 1 + 64 + (FCS ? 4 : 0)));
    check_eq("frame64_sent", 32'(sent_cnt - s0), 32'd1);

    // Back-to-back frames
    s0 = sent_cnt;
    timer = 19'h2A5;
    rand_frame(5);
    queue_frame(timer, 1'b1);
    rand_frame(6);
    queue_frame(timer, 1'b1);
    wait_drain("b2b", 300);
    check_eq("b2b_gap", 32'(last_gap), 32'(IFG));
    check_eq("b2b_sent", 32'(sent_cnt - s0), 32'd2);

    // Underflow after 10 bytes
    s0 = sent_cnt;
    u0 = uf_cnt;
    timer = 19'h7_1234;
    push_header(timer);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      fifo.push_back({(i == 0), b});
      push_exp(b, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    push_exp(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(negedge clk_sys); k++; end
    check_eq("uf_seen", 32'(exp_q.size()), 32'd0);
    p0 = pop_cnt;
    for (int i = 0; i < 3; i++) fifo.push_back({1'b0, 8'(i + 1)});
    fifo.push_back({1'b1, 8'hEE});
    wait_drain("uf_drain", 100);
    check_eq("uf_drain_pops", 32'(pop_cnt - p0), 32'd4);
    check_eq("uf_pulses", 32'(uf_cnt - u0), 32'd1);
    check_eq("uf_no_sent", 32'(sent_cnt - s0), 32'd0);
    rand_frame(3);
    timer = 19'h300;
    queue_frame(timer, 1'b1);
    wait_drain("post_uf", 200);
    check_eq("post_uf_gap_min", {31'd0, (last_gap >= IFG)}, 32'd1);

    // Stray body words at idle
    p0 = pop_cnt;
    e0 = en_cnt;
    for (int i = 0; i < 3; i++) fifo.push_back({1'b0, 8'hA0 + 8'(i)});
    repeat (12) @(negedge clk_sys);
    check_eq("stray_pops", 32'(pop_cnt - p0), 32'd3);
    check_eq("stray_no_tx", 32'(en_cnt - e0), 32'd0);
    check_eq("stray_fifo_empty", 32'(fifo.size()), 32'd0);

`ifdef GMII_WRITE_FCS_EN
    // Check value of the standard CRC32 test string
    s0 = sent_cnt;
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
    timer = 19'h0ABC;
    queue_frame(timer, 1'b0);
    push_exp(8'h26, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    push_exp(8'h39, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    push_exp(8'hF4, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    push_exp(8'hCB, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    wait_drain("fcs_check", 200);
    check_eq("fcs_sent", 32'(sent_cnt - s0), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
